// File: rtl/exec_stage_if.sv
// Bundle of the issue handshake, write-back and debug-read signals of the
// execute stage. The master side issues instructions; the slave side is
// the stage itself.
`timescale 1ns/1ps

interface exec_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op;
    logic [3:0]  r_dest;
    logic [3:0]  r_src;
    logic [15:0] immediate;
    logic        ri;
    logic        c_in;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [4:0]  flags;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    modport master (
        output in_valid, op, r_dest, r_src, immediate, ri, c_in, dbg_addr,
        input  in_ready, wb_valid, wb_addr, wb_data, flags, dbg_data
    );

    modport slave (
        input  in_valid, op, r_dest, r_src, immediate, ri, c_in, dbg_addr,
        output in_ready, wb_valid, wb_addr, wb_data, flags, dbg_data
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: 16x16 register file, single-cycle ALU/shift operations
// and a multi-cycle shift-add multiplier. Flags are {C,L,F,Z,N}.
`timescale 1ns/1ps

module exec_stage #(
    parameter int MUL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    exec_stage_if.slave bus
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_MUL  = 8'h0E;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ASHU = 8'h86;

    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    // Multiplier bits retired per busy cycle so that 16 bits fit in MUL_CYCLES.
    localparam int MUL_BITS = (16 + MUL_CYCLES - 1) / MUL_CYCLES;
    localparam int CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [0:0] {
        ST_READY    = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_regs [16];
    logic [4:0]       r_flags;
    logic [15:0]      r_mul_a;
    logic [15:0]      r_mul_b;
    logic [15:0]      r_mul_acc;
    logic [3:0]       r_mul_dest;
    logic [CNT_W-1:0] r_mul_cnt;
    logic             r_wb_valid;
    logic [3:0]       r_wb_addr;
    logic [15:0]      r_wb_data;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [15:0]      w_a;
    logic [15:0]      w_b;
    logic [15:0]      w_d;
    logic             w_we;
    logic [4:0]       w_flags_next;
    logic [16:0]      w_sum;
    logic [15:0]      w_diff;
    logic [15:0]      w_mul_a_next;
    logic [15:0]      w_mul_b_next;
    logic [15:0]      w_mul_acc_next;

    // Shift by a signed count: positive shifts left, negative shifts right
    // (logical or arithmetic); counts beyond 15 flush the operand out.
    function automatic logic [15:0] f_shift(input logic [15:0] a,
                                            input logic [15:0] s,
                                            input logic        arith);
        logic [15:0] mag;
        logic [15:0] res;
        mag = (~s) + 16'h0001;
        if (!s[15]) begin
            if (s > 16'd15) res = 16'h0000;
            else            res = a << s[3:0];
        end else begin
            if (mag > 16'd15) res = arith ? {16{a[15]}} : 16'h0000;
            else if (arith)   res = $signed(a) >>> mag[3:0];
            else              res = a >> mag[3:0];
        end
        return res;
    endfunction

    assign w_accept = bus.in_valid && (r_state == ST_READY);
    assign w_is_mul = (bus.op == OP_MUL);
    assign w_a      = r_regs[bus.r_dest];
    assign w_b      = bus.ri ? bus.immediate : r_regs[bus.r_src];

    assign bus.in_ready = (r_state == ST_READY);
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_addr  = r_wb_addr;
    assign bus.wb_data  = r_wb_data;
    assign bus.flags    = r_flags;
    assign bus.dbg_data = r_regs[bus.dbg_addr];

    // Next-state logic: enter MUL_BUSY on a MUL accept, leave when the count expires.
    always_comb begin
        w_state_next = r_state;
        w_mul_done   = 1'b0;
        case (r_state)
            ST_READY: begin
                if (w_accept && w_is_mul) w_state_next = ST_MUL_BUSY;
                else                      w_state_next = ST_READY;
            end
            ST_MUL_BUSY: begin
                if (r_mul_cnt == CNT_ZERO) begin
                    w_state_next = ST_READY;
                    w_mul_done   = 1'b1;
                end else begin
                    w_state_next = ST_MUL_BUSY;
                end
            end
            default: w_state_next = ST_READY;
        endcase
    end

    // One shift-add step of the multiplier (MUL_BITS bits of B per cycle).
    always_comb begin
        w_mul_a_next   = r_mul_a;
        w_mul_b_next   = r_mul_b;
        w_mul_acc_next = r_mul_acc;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (w_mul_b_next[0]) w_mul_acc_next = w_mul_acc_next + w_mul_a_next;
            else                 w_mul_acc_next = w_mul_acc_next;
            w_mul_a_next = {w_mul_a_next[14:0], 1'b0};
            w_mul_b_next = {1'b0, w_mul_b_next[15:1]};
        end
    end

    // Single-cycle datapath: result, write enable and next flags for the current op.
    always_comb begin
        w_d          = 16'h0000;
        w_we         = 1'b0;
        w_flags_next = r_flags;
        w_sum        = {1'b0, w_a} + {1'b0, w_b} + {16'h0000, bus.c_in};
        w_diff       = w_a - w_b;
        case (bus.op)
            OP_ADD: begin
                w_d                 = w_sum[15:0];
                w_we                = 1'b1;
                w_flags_next[FLG_C] = w_sum[16];
                w_flags_next[FLG_F] = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
            end
            OP_SUB: begin
                w_d                 = w_diff;
                w_we                = 1'b1;
                w_flags_next[FLG_C] = (w_a < w_b);
                w_flags_next[FLG_F] = (w_a[15] != w_b[15]) && (w_diff[15] != w_a[15]);
            end
            OP_CMP: begin
                w_flags_next[FLG_Z] = (w_a == w_b);
                w_flags_next[FLG_L] = (w_a < w_b);
                w_flags_next[FLG_N] = ($signed(w_a) < $signed(w_b));
            end
            OP_AND: begin
                w_d  = w_a & w_b;
                w_we = 1'b1;
            end
            OP_OR: begin
                w_d  = w_a | w_b;
                w_we = 1'b1;
            end
            OP_XOR: begin
                w_d  = w_a ^ w_b;
                w_we = 1'b1;
            end
            OP_MOV: begin
                w_d  = w_b;
                w_we = 1'b1;
            end
            OP_LSH: begin
                w_d  = f_shift(w_a, w_b, 1'b0);
                w_we = 1'b1;
            end
            OP_ASHU: begin
                w_d  = f_shift(w_a, w_b, 1'b1);
                w_we = 1'b1;
            end
            OP_MUL, OP_NOP: begin
                w_we = 1'b0;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // State, register file, flags, multiplier and write-back registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_READY;
            for (int i = 0; i < 16; i++) r_regs[i] <= 16'h0000;
            r_flags    <= 5'b00000;
            r_mul_a    <= 16'h0000;
            r_mul_b    <= 16'h0000;
            r_mul_acc  <= 16'h0000;
            r_mul_dest <= 4'h0;
            r_mul_cnt  <= CNT_ZERO;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= 4'h0;
            r_wb_data  <= 16'h0000;
        end else begin
            r_state    <= w_state_next;
            r_wb_valid <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_flags <= w_flags_next;
                if (w_we) begin
                    r_regs[bus.r_dest] <= w_d;
                    r_wb_valid         <= 1'b1;
                    r_wb_addr          <= bus.r_dest;
                    r_wb_data          <= w_d;
                end
            end else if (w_accept && w_is_mul) begin
                r_mul_a    <= w_a;
                r_mul_b    <= w_b;
                r_mul_acc  <= 16'h0000;
                r_mul_dest <= bus.r_dest;
                r_mul_cnt  <= CNT_LOAD;
            end else if (r_state == ST_MUL_BUSY) begin
                r_mul_a   <= w_mul_a_next;
                r_mul_b   <= w_mul_b_next;
                r_mul_acc <= w_mul_acc_next;
                if (w_mul_done) begin
                    r_regs[r_mul_dest] <= w_mul_acc_next;
                    r_wb_valid         <= 1'b1;
                    r_wb_addr          <= r_mul_dest;
                    r_wb_data          <= w_mul_acc_next;
                end else begin
                    r_mul_cnt <= r_mul_cnt - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed vector table, multiply and
// reset-abort sequences, then random instructions against a behavioural model.
`timescale 1ns/1ps

module tb_exec_stage;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    exec_stage_if bus();

    exec_stage #(.MUL_CYCLES(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic        ri;
        logic        cin;
        logic        exp_wb;
        logic [15:0] exp_reg;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t tbl[21];

    // behavioural model state
    int       m_r[16];
    bit [4:0] m_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 0;
        m_flags = 5'b00000;
    endtask

    // Executes one instruction on the model from the architectural rules.
    task automatic model_step(input logic [7:0] op, input int rd, input int rs, input int imm,
                              input int ri, input int cin, output bit we, output int d);
        int a, b, sa, sb, t, m;
        longint p;
        a  = m_r[rd];
        b  = (ri != 0) ? imm : m_r[rs];
        sa = sx(a);
        sb = sx(b);
        we = 1'b0;
        d  = 0;
        case (op)
            8'h05: begin
                t = a + b + cin; d = t & 65535; we = 1'b1;
                m_flags[4] = (t > 65535);
                t = sa + sb + cin;
                m_flags[2] = (t > 32767) || (t < -32768);
            end
            8'h09: begin
                d = (a - b + 65536) & 65535; we = 1'b1;
                m_flags[4] = (a < b);
                t = sa - sb;
                m_flags[2] = (t > 32767) || (t < -32768);
            end
            8'h0B: begin
                m_flags[1] = (a == b);
                m_flags[3] = (a < b);
                m_flags[0] = (sa < sb);
            end
            8'h01: begin d = a & b; we = 1'b1; end
            8'h02: begin d = a | b; we = 1'b1; end
            8'h03: begin d = a ^ b; we = 1'b1; end
            8'h0D: begin d = b; we = 1'b1; end
            8'h0E: begin p = longint'(a) * longint'(b); d = int'(p % 65536); we = 1'b1; end
            8'h84, 8'h86: begin
                we = 1'b1;
                if (sb >= 0) begin
                    d = (sb > 15) ? 0 : ((a * (1 << sb)) & 65535);
                end else begin
                    m = -sb;
                    if (op == 8'h84) d = (m > 15) ? 0 : (a / (1 << m));
                    else if (m > 15) d = (sa < 0) ? 65535 : 0;
                    else             d = (sa >>> m) & 65535;
                end
            end
            default: we = 1'b0;
        endcase
        if (we) m_r[rd] = d;
    endtask

    // Issues one instruction, waits for its commit and samples the outputs.
    task automatic run_instr(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                             input logic [15:0] imm, input logic ri, input logic cin,
                             output logic wbv, output logic [3:0] wba, output logic [15:0] wbd,
                             output logic [4:0] flg, output logic [15:0] dbg);
        int k;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.r_dest    = rd;
        bus.r_src     = rs;
        bus.immediate = imm;
        bus.ri        = ri;
        bus.c_in      = cin;
        bus.dbg_addr  = rd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (op == 8'h0E) begin
            k = 0;
            while (!bus.in_ready && k < 64) begin
                @(posedge clk); #1;
                k++;
            end
            check("mul_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        end
        wbv = bus.wb_valid;
        wba = bus.wb_addr;
        wbd = bus.wb_data;
        flg = bus.flags;
        dbg = bus.dbg_data;
    endtask

    task automatic check_all_regs_zero(input string name);
        for (int i = 0; i < 16; i++) begin
            bus.dbg_addr = 4'(i);
            #1;
            check(name, {16'd0, bus.dbg_data}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        wbv;
        logic [3:0]  wba;
        logic [15:0] wbd;
        logic [4:0]  flg;
        logic [15:0] dbg;
        bit          we;
        int          d;
        int          busy;
        logic [7:0]  ops[12];
        logic [7:0]  op;
        logic [3:0]  rd, rs;
        logic [15:0] imm;
        logic        ri, cin;

        bus.in_valid = 1'b0; bus.op = 8'h00; bus.r_dest = 4'h0; bus.r_src = 4'h0;
        bus.immediate = 16'h0000; bus.ri = 1'b0; bus.c_in = 1'b0; bus.dbg_addr = 4'h0;
        model_reset();

        //            op     rd    rs    imm       ri    cin   wb    reg       flags
        tbl[0]  = '{8'h0D, 4'd1, 4'd0, 16'h0007, 1'b1, 1'b0, 1'b1, 16'h0007, 5'b00000};
        tbl[1]  = '{8'h05, 4'd1, 4'd0, 16'hFFF9, 1'b1, 1'b0, 1'b1, 16'h0000, 5'b10000};
        tbl[2]  = '{8'h0D, 4'd2, 4'd0, 16'h7FFF, 1'b1, 1'b0, 1'b1, 16'h7FFF, 5'b10000};
        tbl[3]  = '{8'h05, 4'd2, 4'd0, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h8000, 5'b00100};
        tbl[4]  = '{8'h09, 4'd2, 4'd0, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 5'b00100};
        tbl[5]  = '{8'h0D, 4'd3, 4'd0, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0005, 5'b00100};
        tbl[6]  = '{8'h0D, 4'd4, 4'd0, 16'hFFFB, 1'b1, 1'b0, 1'b1, 16'hFFFB, 5'b00100};
        tbl[7]  = '{8'h0B, 4'd3, 4'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0005, 5'b01100};
        tbl[8]  = '{8'h0B, 4'd3, 4'd0, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0005, 5'b00110};
        tbl[9]  = '{8'h0D, 4'd5, 4'd0, 16'h8010, 1'b1, 1'b0, 1'b1, 16'h8010, 5'b00110};
        tbl[10] = '{8'h84, 4'd5, 4'd0, 16'hFFFC, 1'b1, 1'b0, 1'b1, 16'h0801, 5'b00110};
        tbl[11] = '{8'h0D, 4'd5, 4'd0, 16'h8010, 1'b1, 1'b0, 1'b1, 16'h8010, 5'b00110};
        tbl[12] = '{8'h86, 4'd5, 4'd0, 16'hFFFC, 1'b1, 1'b0, 1'b1, 16'hF801, 5'b00110};
        tbl[13] = '{8'h0D, 4'd5, 4'd0, 16'h8010, 1'b1, 1'b0, 1'b1, 16'h8010, 5'b00110};
        tbl[14] = '{8'h84, 4'd5, 4'd0, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h0000, 5'b00110};
        tbl[15] = '{8'h00, 4'd5, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00110};
        tbl[16] = '{8'h7F, 4'd5, 4'd0, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000, 5'b00110};
        tbl[17] = '{8'h05, 4'd6, 4'd0, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0004, 5'b00010};
        tbl[18] = '{8'h01, 4'd4, 4'd0, 16'h0F0F, 1'b1, 1'b0, 1'b1, 16'h0F0B, 5'b00010};
        tbl[19] = '{8'h02, 4'd4, 4'd0, 16'hF000, 1'b1, 1'b0, 1'b1, 16'hFF0B, 5'b00010};
        tbl[20] = '{8'h03, 4'd4, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h80F4, 5'b00010};

        ops = '{8'h05, 8'h09, 8'h0E, 8'h02, 8'h0B, 8'h01, 8'h03, 8'h0D, 8'h84, 8'h86, 8'h00, 8'h47};

        // reset and post-reset state
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("rst_wb_addr",  {28'd0, bus.wb_addr},  32'd0);
        check("rst_wb_data",  {16'd0, bus.wb_data},  32'd0);
        check("rst_flags",    {27'd0, bus.flags},    32'd0);
        check_all_regs_zero("rst_reg");

        // directed vector table, issued back to back
        for (int i = 0; i < 21; i++) begin
            model_step(tbl[i].op, int'(tbl[i].rd), int'(tbl[i].rs), int'(tbl[i].imm),
                       int'(tbl[i].ri), int'(tbl[i].cin), we, d);
            run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, tbl[i].ri, tbl[i].cin,
                      wbv, wba, wbd, flg, dbg);
            check($sformatf("vec%0d_wb_valid", i), {31'd0, wbv}, {31'd0, tbl[i].exp_wb});
            check($sformatf("vec%0d_flags", i), {27'd0, flg}, {27'd0, tbl[i].exp_flags});
            check($sformatf("vec%0d_reg", i), {16'd0, dbg}, {16'd0, tbl[i].exp_reg});
            if (tbl[i].exp_wb) begin
                check($sformatf("vec%0d_wb_addr", i), {28'd0, wba}, {28'd0, tbl[i].rd});
                check($sformatf("vec%0d_wb_data", i), {16'd0, wbd}, {16'd0, tbl[i].exp_reg});
            end
        end

        // MUL R6,R7 with in_valid held high through the busy period
        model_step(8'h0D, 6, 0, 16'h00FF, 1, 0, we, d);
        run_instr(8'h0D, 4'd6, 4'd0, 16'h00FF, 1'b1, 1'b0, wbv, wba, wbd, flg, dbg);
        model_step(8'h0D, 7, 0, 16'h0101, 1, 0, we, d);
        run_instr(8'h0D, 4'd7, 4'd0, 16'h0101, 1'b1, 1'b0, wbv, wba, wbd, flg, dbg);
        check("mul_setup_r7", {16'd0, dbg}, 32'h0000_0101);
        model_step(8'h0E, 6, 7, 0, 0, 0, we, d);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 8'h0E; bus.r_dest = 4'd6; bus.r_src = 4'd7;
        bus.ri = 1'b0; bus.c_in = 1'b0; bus.dbg_addr = 4'd6;
        @(posedge clk); #1;
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.in_ready) break;
            busy++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("mul_busy_cycles", busy, 32'd16);
        check("mul_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("mul_wb_addr",  {28'd0, bus.wb_addr},  32'd6);
        check("mul_wb_data",  {16'd0, bus.wb_data},  32'h0000_FFFF);
        check("mul_model",    {16'd0, bus.wb_data},  d);
        check("mul_flags",    {27'd0, bus.flags},    32'b00010);
        check("mul_reg",      {16'd0, bus.dbg_data}, 32'h0000_FFFF);
        @(posedge clk); #1;
        check("mul_wb_pulse_end", {31'd0, bus.wb_valid}, 32'd0);
        check("mul_no_reaccept",  {31'd0, bus.in_ready}, 32'd1);

        // reset asserted at busy cycle 5 of a MUL aborts it
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 8'h0E; bus.r_dest = 4'd6; bus.r_src = 4'd7;
        bus.ri = 1'b0; bus.dbg_addr = 4'd6;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("abort_busy", {31'd0, bus.in_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("abort_flags",    {27'd0, bus.flags},    32'd0);
        busy = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.wb_valid) busy++;
        end
        check("abort_no_write", busy, 32'd0);
        check_all_regs_zero("abort_reg");
        model_step(8'h05, 1, 0, 16'h0003, 1, 0, we, d);
        run_instr(8'h05, 4'd1, 4'd0, 16'h0003, 1'b1, 1'b0, wbv, wba, wbd, flg, dbg);
        check("post_abort_add_wb", {31'd0, wbv}, 32'd1);
        check("post_abort_add_r1", {16'd0, dbg}, 32'h0000_0003);
        check("post_abort_flags",  {27'd0, flg}, 32'd0);

        // random instructions against the model
        for (int n = 0; n < 400; n++) begin
            op  = ops[$urandom_range(0, 11)];
            rd  = 4'($urandom_range(0, 15));
            rs  = 4'($urandom_range(0, 15));
            ri  = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            if ((op == 8'h84 || op == 8'h86) && $urandom_range(0, 3) != 0)
                imm = 16'($urandom_range(0, 40)) - 16'd20;
            else
                imm = 16'($urandom);
            model_step(op, int'(rd), int'(rs), int'(imm), int'(ri), int'(cin), we, d);
            run_instr(op, rd, rs, imm, ri, cin, wbv, wba, wbd, flg, dbg);
            check("rnd_wb_valid", {31'd0, wbv}, {31'd0, we});
            if (we) begin
                check("rnd_wb_addr", {28'd0, wba}, {28'd0, rd});
                check("rnd_wb_data", {16'd0, wbd}, d);
            end
            check("rnd_flags", {27'd0, flg}, {27'd0, m_flags});
            check("rnd_reg",   {16'd0, dbg}, m_r[rd]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
